// File: rtl/dm_pkg.sv
// Shared types and helpers for the handshaked data memory.
// DATA_MEM_PARITY_EN (see dm_ram_core) adds a per-word parity column.
package dm_pkg;

    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned MaxDataW  = 64;
    localparam int unsigned MaxBeW    = MaxDataW / 8;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Replace each enabled byte lane of old_word with the matching lane of new_word.
    function automatic logic [MaxDataW-1:0] merge_lanes(input logic [MaxDataW-1:0] old_word,
                                                        input logic [MaxDataW-1:0] new_word,
                                                        input logic [MaxBeW-1:0]   be);
        logic [MaxDataW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(MaxBeW); i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_ram_core.sv
// Synchronous word RAM with byte-lane writes and a registered read port.
// DATA_MEM_PARITY_EN: stores even parity per word and flags mismatches on read.
module dm_ram_core
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata,
    output logic              par_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = DATA_W'(merge_lanes(MaxDataW'(mem[addr]), MaxDataW'(wdata), MaxBeW'(be)));
    end

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merged;
        if (re) rdata <= mem[addr];
    end

`ifdef DATA_MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_q;

    always_ff @(posedge clk) begin
        if (we) par_mem[addr] <= ^merged;
        if (re) par_q <= par_mem[addr];
    end

    assign par_err = par_q ^ (^rdata);

    // Test hook: corrupt the stored parity bit of one word.
    task automatic flip_parity(input logic [AW-1:0] a);
        par_mem[a] = ~par_mem[a];
    endtask
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/data_mem_hs.sv
// Word-addressed RAM behind valid/ready request/response handshakes with WAIT_CYC wait states.
// Optional DATA_MEM_PARITY_EN adds parity checking on reads.
module data_mem_hs
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 1,
    localparam int unsigned BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned RamAw = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              rd_q;
    logic              err_q;
    logic              access;
    logic              in_range;
    logic [DATA_W-1:0] ram_rdata;
    logic              par_err;

    assign in_range = 32'(addr_q) < DEPTH;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = WAIT_W'(WAIT_CYC);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            // rd_q gates read data onto rsp_rdata; cleared once the response is consumed.
            if (access) begin
                rd_q  <= ~we_q & in_range;
                err_q <= ~in_range;
            end else if (state_q == StResp && rsp_ready) begin
                rd_q  <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    dm_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RamAw),
        .BE_W   (BE_W)
    ) u_ram (
        .clk     (clk),
        .we      (access & we_q & in_range),
        .re      (access & ~we_q & in_range),
        .addr    (addr_q[RamAw-1:0]),
        .wdata   (wdata_q),
        .be      (be_q),
        .rdata   (ram_rdata),
        .par_err (par_err)
    );

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rd_q ? ram_rdata : '0;
    assign rsp_err   = err_q | (rd_q & par_err);

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed self-checking bench for data_mem_hs (WAIT_CYC=3, 16-bit words, 256 entries).
module tb_data_mem_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_hs #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (256),
        .WAIT_CYC (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [15:0] rdata, output logic err, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, output logic [15:0] rdata, output logic err,
                        output int lat);
        issue(we, addr, wdata, be);
        wait_rsp(rdata, err, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] d; logic e; int l;
        xact(1'b1, 16'd1, 16'h0002, 2'b11, d, e, l);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL basic_wr_rdata: got %h want 0000", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b want 0", e); end
        xact(1'b0, 16'd1, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL basic_rd_rdata: got %h want 0002", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b want 0", e); end
    endtask

    task automatic test_lanes;
        logic [15:0] d; logic e; int l;
        xact(1'b1, 16'd5, 16'hABCD, 2'b11, d, e, l);
        xact(1'b1, 16'd5, 16'h1200, 2'b10, d, e, l);
        xact(1'b0, 16'd5, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h12CD) begin errors++; $display("FAIL lane_merge: got %h want 12cd", d); end
        xact(1'b1, 16'd5, 16'hFFFF, 2'b00, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err: got %b want 0", e); end
        xact(1'b0, 16'd5, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h12CD) begin errors++; $display("FAIL be0_nochange: got %h want 12cd", d); end
    endtask

    task automatic test_latency;
        int  lat;
        logic bad_ready, bad_busy;
        issue(1'b0, 16'd5, 16'h0, 2'b00);
        lat = 0; bad_ready = 1'b0; bad_busy = 1'b0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (req_ready) bad_ready = 1'b1;
            if (!busy) bad_busy = 1'b1;
        end
        // Accept edge N; first negedge after edge N+4 is the fifth one.
        checks++; if (lat != 5) begin errors++; $display("FAIL latency: got %0d negedges want 5", lat); end
        checks++; if (bad_ready) begin errors++; $display("FAIL latency_req_ready: got 1 during wait want 0"); end
        checks++; if (bad_busy) begin errors++; $display("FAIL latency_busy: got 0 during wait want 1"); end
        checks++; if (rsp_rdata !== 16'h12CD) begin errors++; $display("FAIL latency_rdata: got %h want 12cd", rsp_rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        logic [15:0] d; logic e; int l;
        logic bad_v, bad_d, bad_r;
        rsp_ready = 1'b0;
        issue(1'b0, 16'd5, 16'h0, 2'b00);
        l = 0;
        while (!rsp_valid && l < 100) begin @(negedge clk); l++; end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'h0000; req_be = 2'b11;
        bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1) bad_v = 1'b1;
            if (rsp_rdata !== 16'h12CD) bad_d = 1'b1;
            if (req_ready !== 1'b0) bad_r = 1'b1;
        end
        checks++; if (bad_v) begin errors++; $display("FAIL bp_valid: got drop want held 1"); end
        checks++; if (bad_d) begin errors++; $display("FAIL bp_rdata: got %h want stable 12cd", rsp_rdata); end
        checks++; if (bad_r) begin errors++; $display("FAIL bp_req_ready: got 1 want 0"); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
        xact(1'b0, 16'd5, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h12CD) begin errors++; $display("FAIL bp_second_ignored: got %h want 12cd", d); end
    endtask

    task automatic test_range;
        logic [15:0] d; logic e; int l;
        xact(1'b1, 16'd0, 16'h5A5A, 2'b11, d, e, l);
        xact(1'b1, 16'd256, 16'hFFFF, 2'b11, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", e); end
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL oor_wr_rdata: got %h want 0000", d); end
        checks++; if (l != 5) begin errors++; $display("FAIL oor_latency: got %0d want 5", l); end
        xact(1'b0, 16'd256, 16'h0, 2'b00, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", e); end
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL oor_rd_rdata: got %h want 0000", d); end
        xact(1'b0, 16'd0, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL oor_mem0: got %h want 5a5a", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_mem0_err: got %b want 0", e); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d; logic e; int l;
        xact(1'b1, 16'd7, 16'h1111, 2'b11, d, e, l);
        issue(1'b1, 16'd7, 16'h2222, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mid_rsp: got %h/%b want 0000/0", rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 16'd7, 16'h0, 2'b00, d, e, l);
        checks++; if (d !== 16'h1111) begin errors++; $display("FAIL mid_mem7: got %h want 1111", d); end
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity;
        logic [15:0] d; logic e; int l;
        xact(1'b1, 16'd3, 16'h00F0, 2'b11, d, e, l);
        xact(1'b0, 16'd3, 16'h0, 2'b00, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL par_clean: got %b want 0", e); end
        dut.u_ram.flip_parity(8'd3);
        xact(1'b0, 16'd3, 16'h0, 2'b00, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", e); end
        checks++; if (d !== 16'h00F0) begin errors++; $display("FAIL par_data: got %h want 00f0", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_latency();
        test_backpressure();
        test_range();
        test_reset_mid();
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
